// File: rtl/usb_rx_pkg.sv
// Shared USB receive-path definitions: checker FSM states and the CRC16 constants
// also used by the transmitter's CRC generator.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        CHECK
    } crc_chk_state_t;

    localparam logic [15:0] USB_CRC16_POLY     = 16'h8005;
    localparam logic [15:0] USB_CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] USB_CRC16_RESIDUAL = 16'h800D;

endpackage

// File: rtl/crc16_serial_lfsr.sv
// Serial CRC16 register, one bit per shift, MSB-first feedback (USB wire ordering).
// A load takes priority over a shift in the same cycle.
module crc16_serial_lfsr
    import usb_rx_pkg::*;
#(
    parameter logic [15:0] POLY = USB_CRC16_POLY,
    parameter logic [15:0] INIT = USB_CRC16_INIT
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        shift,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic        fb;

    always_comb begin
        fb    = crc_q[15] ^ bit_in;
        crc_d = crc_q;
        if (load) begin
            crc_d = seed;
        end else if (shift) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/usb_crc16_checker.sv
// Receive-side USB CRC16 checker: accumulates de-stuffed bits between sop and eop,
// then latches pass/fail and length verdicts that hold until the next sop.
module usb_crc16_checker
    import usb_rx_pkg::*;
#(
    parameter logic [15:0] POLY     = USB_CRC16_POLY,
    parameter logic [15:0] INIT     = USB_CRC16_INIT,
    parameter logic [15:0] RESIDUAL = USB_CRC16_RESIDUAL,
    parameter int          MAX_BITS = 1024
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        sop,
    input  logic        bit_in,
    input  logic        new_bit,
    input  logic        eop,
    output logic        crc_done,
    output logic        crc_ok,
    output logic        crc_err,
    output logic        len_err,
    output logic [15:0] crc_value,
    output logic [10:0] bit_count
);

    localparam logic [10:0] MAX_COUNT = 11'(MAX_BITS);

    crc_chk_state_t state_q, state_d;
    logic [10:0]    bit_count_q, bit_count_d;
    logic           crc_done_q, crc_done_d;
    logic           crc_ok_q, crc_ok_d;
    logic           crc_err_q, crc_err_d;
    logic           len_err_q, len_err_d;
    logic           clr_pending_q, clr_pending_d;

    logic           lfsr_load;
    logic           lfsr_shift;
    logic [15:0]    crc_reg;
    logic           len_err_now;
    logic           crc_err_now;

    crc16_serial_lfsr #(
        .POLY (POLY),
        .INIT (INIT)
    ) u_lfsr (
        .clk    (clk),
        .n_rst  (n_rst),
        .load   (lfsr_load),
        .seed   (INIT),
        .shift  (lfsr_shift),
        .bit_in (bit_in),
        .crc    (crc_reg)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            bit_count_q   <= 11'd0;
            crc_done_q    <= 1'b0;
            crc_ok_q      <= 1'b0;
            crc_err_q     <= 1'b0;
            len_err_q     <= 1'b0;
            clr_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_count_q   <= bit_count_d;
            crc_done_q    <= crc_done_d;
            crc_ok_q      <= crc_ok_d;
            crc_err_q     <= crc_err_d;
            len_err_q     <= len_err_d;
            clr_pending_q <= clr_pending_d;
        end
    end

    // sop always wins over eop; a sop during CHECK starts the next packet directly
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sop) state_d = ACCUM;
            ACCUM:   if (!sop && eop) state_d = CHECK;
            CHECK:   state_d = sop ? ACCUM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lfsr_load     = 1'b0;
        lfsr_shift    = 1'b0;
        bit_count_d   = bit_count_q;
        crc_done_d    = 1'b0;
        crc_ok_d      = crc_ok_q;
        crc_err_d     = crc_err_q;
        len_err_d     = len_err_q;
        clr_pending_d = 1'b0;
        len_err_now   = (bit_count_q < 11'd16) | (bit_count_q[2:0] != 3'd0);
        crc_err_now   = (crc_reg != RESIDUAL);

        unique case (state_q)
            IDLE: begin
                if (sop) begin
                    lfsr_load   = 1'b1;
                    bit_count_d = 11'd0;
                    crc_ok_d    = 1'b0;
                    crc_err_d   = 1'b0;
                    len_err_d   = 1'b0;
                end
            end
            ACCUM: begin
                // Verdicts from the previous packet survive one cycle when sop hit CHECK
                if (clr_pending_q) begin
                    crc_ok_d  = 1'b0;
                    crc_err_d = 1'b0;
                    len_err_d = 1'b0;
                end
                if (sop) begin
                    lfsr_load   = 1'b1;
                    bit_count_d = 11'd0;
                    crc_ok_d    = 1'b0;
                    crc_err_d   = 1'b0;
                    len_err_d   = 1'b0;
                end else if (new_bit) begin
                    lfsr_shift  = 1'b1;
                    bit_count_d = (bit_count_q < MAX_COUNT) ? bit_count_q + 11'd1 : bit_count_q;
                end
            end
            CHECK: begin
                crc_done_d = 1'b1;
                len_err_d  = len_err_now;
                crc_err_d  = crc_err_now;
                crc_ok_d   = ~len_err_now & ~crc_err_now;
                if (sop) begin
                    lfsr_load     = 1'b1;
                    bit_count_d   = 11'd0;
                    clr_pending_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign crc_done  = crc_done_q;
    assign crc_ok    = crc_ok_q;
    assign crc_err   = crc_err_q;
    assign len_err   = len_err_q;
    assign crc_value = crc_reg;
    assign bit_count = bit_count_q;

endmodule

// File: tb/tb_usb_crc16_checker.sv
// Self-checking bench for usb_crc16_checker: directed packets plus randomized ones,
// all judged against a polynomial long-division CRC model.
module tb_usb_crc16_checker;

    localparam logic [15:0] RESIDUAL_V = 16'h800D;
    localparam int          MAX_BITS_V = 1024;

    logic        clk;
    logic        n_rst;
    logic        sop;
    logic        bit_in;
    logic        new_bit;
    logic        eop;
    logic        crc_done;
    logic        crc_ok;
    logic        crc_err;
    logic        len_err;
    logic [15:0] crc_value;
    logic [10:0] bit_count;

    int checks = 0;
    int errors = 0;
    bit pkt_bits[$];
    bit exp_ok_g;

    usb_crc16_checker dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .sop       (sop),
        .bit_in    (bit_in),
        .new_bit   (new_bit),
        .eop       (eop),
        .crc_done  (crc_done),
        .crc_ok    (crc_ok),
        .crc_err   (crc_err),
        .len_err   (len_err),
        .crc_value (crc_value),
        .bit_count (bit_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register after n bits = (INIT * x^n + M(x) * x^16) mod P, by long division.
    function automatic logic [15:0] model_crc();
        int          n;
        bit          d[];
        logic [15:0] poly_v;
        logic [15:0] init_v;
        logic [15:0] r;
        n      = pkt_bits.size();
        poly_v = 16'h8005;
        init_v = 16'hFFFF;
        d      = new[n + 16];
        foreach (d[i]) d[i] = 1'b0;
        for (int i = 0; i < 16; i++) d[i] = init_v[15 - i];
        for (int i = 0; i < n; i++) d[i] = d[i] ^ pkt_bits[i];
        for (int i = 0; i < n; i++) begin
            if (d[i]) begin
                for (int k = 0; k < 16; k++) d[i + 1 + k] = d[i + 1 + k] ^ poly_v[15 - k];
            end
        end
        for (int k = 0; k < 16; k++) r[15 - k] = d[n + k];
        return r;
    endfunction

    task automatic applyStimulus(input logic s, input logic b, input logic nb, input logic e);
        sop     = s;
        bit_in  = b;
        new_bit = nb;
        eop     = e;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
        end
    endtask

    task automatic pushByteLsb(input logic [7:0] v);
        for (int i = 0; i < 8; i++) pkt_bits.push_back(v[i]);
    endtask

    task automatic appendCrc();
        logic [15:0] c;
        c = model_crc();
        for (int k = 15; k >= 0; k--) pkt_bits.push_back(~c[k]);
    endtask

    task automatic feedBits(input bit eop_last, input int gap_pct);
        int n;
        n = pkt_bits.size();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(99) < gap_pct) applyStimulus(1'b0, 1'($urandom), 1'b0, 1'b0);
            applyStimulus(1'b0, pkt_bits[i], 1'b1, (eop_last && i == n - 1));
        end
        if (!eop_last || n == 0) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic checkVerdict(input string tag);
        logic [15:0] exp_crc;
        int          cnt;
        bit          exp_len;
        bit          exp_cerr;
        exp_crc  = model_crc();
        cnt      = (pkt_bits.size() > MAX_BITS_V) ? MAX_BITS_V : pkt_bits.size();
        exp_len  = (cnt < 16) || (cnt % 8 != 0);
        exp_cerr = (exp_crc != RESIDUAL_V);
        exp_ok_g = !exp_len && !exp_cerr;
        checkOutput({tag, "_done"},  16'(crc_done),  16'd1);
        checkOutput({tag, "_crc"},   crc_value,      exp_crc);
        checkOutput({tag, "_cnt"},   16'(bit_count), 16'(cnt));
        checkOutput({tag, "_len"},   16'(len_err),   16'(exp_len));
        checkOutput({tag, "_cerr"},  16'(crc_err),   16'(exp_cerr));
        checkOutput({tag, "_ok"},    16'(crc_ok),    16'(exp_ok_g));
    endtask

    task automatic runPacket(input string tag, input bit eop_last, input bit skip_sop,
                             input int gap_pct);
        if (!skip_sop) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput({tag, "_sop_crc"}, crc_value, 16'hFFFF);
            checkOutput({tag, "_sop_cnt"}, 16'(bit_count), 16'd0);
            checkOutput({tag, "_sop_ok"},  16'(crc_ok), 16'd0);
        end
        feedBits(eop_last, gap_pct);
        checkOutput({tag, "_early_done"}, 16'(crc_done), 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkVerdict(tag);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, "_pulse_end"}, 16'(crc_done), 16'd0);
        checkOutput({tag, "_hold_ok"},   16'(crc_ok),   16'(exp_ok_g));
    endtask

    initial begin
        n_rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;

        // Reset in the middle of a packet
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) applyStimulus(1'b0, 1'($urandom), 1'b1, 1'b0);
        n_rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_crc",  crc_value,       16'hFFFF);
        checkOutput("rst_cnt",  16'(bit_count),  16'd0);
        checkOutput("rst_done", 16'(crc_done),   16'd0);
        checkOutput("rst_ok",   16'(crc_ok),     16'd0);
        checkOutput("rst_cerr", 16'(crc_err),    16'd0);
        checkOutput("rst_len",  16'(len_err),    16'd0);
        n_rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_ign_crc",  crc_value,      16'hFFFF);
        checkOutput("idle_ign_cnt",  16'(bit_count), 16'd0);
        checkOutput("idle_ign_done", 16'(crc_done),  16'd0);

        // Minimal good packet: 16 zero bits leave the residual
        pkt_bits.delete();
        repeat (16) pkt_bits.push_back(1'b0);
        runPacket("min_good", 1'b0, 1'b0, 0);
        checkOutput("min_good_res", crc_value, 16'h800D);
        checkOutput("min_good_ok1", 16'(crc_ok), 16'd1);

        // Reset clears held verdicts
        n_rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;
        checkOutput("rst2_ok", 16'(crc_ok), 16'd0);

        pkt_bits.delete();
        repeat (16) pkt_bits.push_back(1'b1);
        runPacket("corrupt", 1'b0, 1'b0, 0);
        checkOutput("corrupt_cerr1", 16'(crc_err), 16'd1);

        pkt_bits.delete();
        pushByteLsb(8'h00);
        appendCrc();
        runPacket("byte00", 1'b1, 1'b0, 0);
        checkOutput("byte00_ok1",  16'(crc_ok),    16'd1);
        checkOutput("byte00_cnt24", 16'(bit_count), 16'd24);

        pkt_bits.delete();
        repeat (12) pkt_bits.push_back(1'($urandom));
        runPacket("len12", 1'b0, 1'b0, 0);
        checkOutput("len12_len1", 16'(len_err), 16'd1);
        pkt_bits.delete();
        repeat (20) pkt_bits.push_back(1'($urandom));
        runPacket("len20", 1'b1, 1'b0, 0);
        checkOutput("len20_len1", 16'(len_err), 16'd1);

        // Abort after 8 bits, restart with a good packet
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'($urandom), 1'b1, 1'b0);
            checkOutput("abort_seg_done", 16'(crc_done), 16'd0);
        end
        pkt_bits.delete();
        repeat (16) pkt_bits.push_back(1'b0);
        runPacket("abort", 1'b0, 1'b0, 0);
        checkOutput("abort_ok1",   16'(crc_ok),    16'd1);
        checkOutput("abort_cnt16", 16'(bit_count), 16'd16);

        // sop and eop together in ACCUM: restart, no verdict
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (8) applyStimulus(1'b0, 1'($urandom), 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("sopeop_crc", crc_value,      16'hFFFF);
        checkOutput("sopeop_cnt", 16'(bit_count), 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("sopeop_nodone", 16'(crc_done), 16'd0);
        pkt_bits.delete();
        repeat (2) pushByteLsb(8'($urandom));
        appendCrc();
        runPacket("sopeop_next", 1'b0, 1'b1, 20);

        // sop during CHECK: verdict still pulses, clears a cycle later
        pkt_bits.delete();
        repeat (16) pkt_bits.push_back(1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        feedBits(1'b1, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("chksop_done", 16'(crc_done),  16'd1);
        checkOutput("chksop_ok",   16'(crc_ok),    16'd1);
        checkOutput("chksop_crc",  crc_value,      16'hFFFF);
        checkOutput("chksop_cnt",  16'(bit_count), 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("chksop_done0", 16'(crc_done), 16'd0);
        checkOutput("chksop_clr",   16'(crc_ok),   16'd0);
        pkt_bits.delete();
        repeat (3) pushByteLsb(8'($urandom));
        appendCrc();
        runPacket("chksop_next", 1'b0, 1'b1, 20);

        for (int p = 0; p < 12; p++) begin
            int kind;
            int flip;
            kind = int'($urandom_range(2));
            pkt_bits.delete();
            if (kind == 2) begin
                repeat ($urandom_range(50)) pkt_bits.push_back(1'($urandom));
            end else begin
                repeat ($urandom_range(1, 5)) pushByteLsb(8'($urandom));
                appendCrc();
                if (kind == 1) begin
                    flip = int'($urandom_range(pkt_bits.size() - 1));
                    pkt_bits[flip] = ~pkt_bits[flip];
                end
            end
            runPacket($sformatf("rnd%0d", p), 1'($urandom), 1'b0, 30);
        end

        // Long packet: counter saturates, CRC keeps running
        pkt_bits.delete();
        repeat (1030) pkt_bits.push_back(1'($urandom));
        runPacket("sat", 1'b0, 1'b0, 0);
        checkOutput("sat_cnt", 16'(bit_count), 16'd1024);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
